simon_input_checker: RTL and testbench
======================================

Name: simon_input_checker

Overview:
- Consumes debounced button levels from the Debounce instances and checks the player's entry against the stored Simon sequence for the current round.
- Sits downstream of Debounce and of the flash stage, and upstream of the result-message stage, which takes `done` and `correct`.
- Adds press edge detection, release interlock, per-press LED feedback and an inactivity timeout.

Parameters:
- SEQ_W, 8: sequence length in bits.
- IDX_W, 4: width of the `index` output; must satisfy 2^IDX_W > SEQ_W.
- TIMEOUT_CYCLES, 300_000_000: idle cycles allowed between presses before the attempt fails (3 s at 100 MHz).
- HOLD_CYCLES, 25_000_000: minimum LED feedback time per press (250 ms).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; arms a new check.
- round  in  IDX_W  last bit index to check (round 0 checks 1 bit).
- sequence  in  SEQ_W  expected bits; 1 = right, 0 = left.
- right_pressed  in  1  debounced right button level.
- left_pressed  in  1  debounced left button level.
- led_pressed  out  2  feedback: 2'b01 right, 2'b10 left, 2'b00 none.
- index  out  IDX_W  number of bits accepted so far.
- correct  out  1  result; valid only while `done` = 1.
- done  out  1  level; check finished.

Behaviour:
- Reset (async assert, sync release): state IDLE; `led_pressed`=0, `index`=0, `correct`=0, `done`=0; timers cleared.
- Inputs are registered once. A press is the rising edge of a registered level, detected by comparing against a second register.
- `round` and `sequence` are latched on `start`; later changes are ignored. A latched `round` ≥ SEQ_W clamps to SEQ_W-1.
- Bit order: press k is compared with sequence[k] (LSB first).
- IDLE
  - Outputs hold their last values.
  - `start` → ARM: `index`=0, `correct`=0, `done`=0, timeout counter cleared.
- ARM
  - Waits until both buttons read released, so a press held over from earlier does not count.
  - Then → WAIT.
- WAIT
  - Timeout counter increments every cycle.
  - Single rising edge: `led_pressed` is set. If the button matches sequence[index], go to HOLD with `index`+1; otherwise → DONE with `correct`=0.
  - Both rising edges in the same cycle: wrong; → DONE with `correct`=0 and `led_pressed`=2'b11.
  - Counter reaches TIMEOUT_CYCLES-1 with no edge: → DONE with `correct`=0; `index` unchanged.
- HOLD
  - Keeps `led_pressed` for at least HOLD_CYCLES and until both buttons are released; presses here are ignored.
  - Exit: clears `led_pressed` and the timeout counter.
  - If `index` = round+1 → DONE with `correct`=1; else → WAIT.
- DONE
  - `done`=1 and `correct` hold indefinitely.
  - `start` → ARM, clearing `done`, `correct` and `index` on the next edge.
  - `led_pressed` clears after HOLD_CYCLES.
- `start` while in ARM, WAIT or HOLD is ignored; an attempt cannot be aborted except by reset.
- `reset_n` low mid-attempt returns to IDLE immediately with all outputs 0.
- Latency:
  - Button edge at the pins → state decision: 2 cycles.
  - Final correct press → `done`=1 no earlier than HOLD_CYCLES after the press, and only after release.
  - Wrong press → `done`=1 two cycles after the pin edge.
- Counters saturate, never wrap. `index` never exceeds round+1.

Test Plan:
- Correct full round: sequence=8'b01100110, round=7, presses L,R,R,L,L,R,R,L with releases → `index` steps 1..8, `done`=1, `correct`=1, `led_pressed` 01/10 matching each press.
- Wrong press: same sequence, round=3, presses L,R,L → `done`=1 two cycles after the third press, `correct`=0, `index`=2.
- Timeout (TIMEOUT_CYCLES=100 for sim): start, then no press → `done`=1 exactly 100 cycles after entering WAIT, `correct`=0, `index`=0.
- Interlock:
  - Hold R from before `start` → no bit accepted until R is released and pressed again.
  - Press L during HOLD (R still down) → ignored, `index` unchanged.
- Simultaneous R+L rising in the same cycle → `done`=1, `correct`=0, `led_pressed`=2'b11.
- Async reset mid-HOLD with `index`=3 → all outputs 0 immediately; a following `start` with round=0 and a single correct press → `done`=1, `correct`=1, `index`=1.

Source files
------------

// File: rtl/simon_input_checker.sv
// Simon input checker: registers debounced button levels, detects presses,
// compares them LSB-first against the latched sequence for the current round,
// and reports done/correct. Includes release interlock, per-press LED feedback
// and an inactivity timeout.
module simon_input_checker #(
    parameter int SEQ_W          = 8,
    parameter int IDX_W          = 4,
    parameter int TIMEOUT_CYCLES = 300_000_000,
    parameter int HOLD_CYCLES    = 25_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [IDX_W-1:0] round,
    // Expected bits, 1 = right; named sequence_bits because 'sequence' is a keyword
    input  logic [SEQ_W-1:0] sequence_bits,
    input  logic             right_pressed,
    input  logic             left_pressed,
    output logic [1:0]       led_pressed,
    output logic [IDX_W-1:0] index,
    output logic             correct,
    output logic             done
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HO_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_HOLD, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             r_q, r_prev_q, l_q, l_prev_q;
    logic [IDX_W-1:0] round_q, round_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [1:0]       led_q, led_d;
    logic             correct_q, correct_d;
    logic             done_q, done_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [HO_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic             rise_r, rise_l, released, exp_bit, hold_met;
    logic [SEQ_W-1:0] seq_shift;
    logic [IDX_W-1:0] round_clamp, last_idx;

    assign rise_r      = r_q & ~r_prev_q;
    assign rise_l      = l_q & ~l_prev_q;
    assign released    = ~r_q & ~l_q;
    assign seq_shift   = seq_q >> index_q;
    assign exp_bit     = seq_shift[0];
    assign hold_met    = (hold_cnt_q == HO_W'(HOLD_CYCLES - 1));
    assign round_clamp = (round >= IDX_W'(SEQ_W)) ? IDX_W'(SEQ_W - 1) : round;
    assign last_idx    = round_q + IDX_W'(1);

    assign led_pressed = led_q;
    assign index       = index_q;
    assign correct     = correct_q;
    assign done        = done_q;

    // Next-state and output decisions for the check FSM
    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        seq_d      = seq_q;
        index_d    = index_q;
        led_d      = led_q;
        correct_d  = correct_q;
        done_d     = done_q;
        to_cnt_d   = to_cnt_q;
        hold_cnt_d = hold_cnt_q;

        // A new attempt may only begin from IDLE or DONE
        if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
            state_d   = S_ARM;
            round_d   = round_clamp;
            seq_d     = sequence_bits;
            index_d   = '0;
            led_d     = 2'b00;
            correct_d = 1'b0;
            done_d    = 1'b0;
            to_cnt_d  = '0;
        end else begin
            case (state_q)
                S_ARM: begin
                    if (released) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (rise_r || rise_l) begin
                        led_d      = {rise_l, rise_r};
                        hold_cnt_d = '0;
                        if (!(rise_r && rise_l) && (rise_r == exp_bit)) begin
                            index_d = index_q + IDX_W'(1);
                            state_d = S_HOLD;
                        end else begin
                            correct_d = 1'b0;
                            done_d    = 1'b1;
                            state_d   = S_DONE;
                        end
                    end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        correct_d  = 1'b0;
                        done_d     = 1'b1;
                        hold_cnt_d = '0;
                        state_d    = S_DONE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                S_HOLD: begin
                    if (!hold_met) hold_cnt_d = hold_cnt_q + HO_W'(1);
                    if (hold_met && released) begin
                        led_d    = 2'b00;
                        to_cnt_d = '0;
                        if (index_q == last_idx) begin
                            correct_d  = 1'b1;
                            done_d     = 1'b1;
                            hold_cnt_d = '0;
                            state_d    = S_DONE;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    // LED feedback from the final press fades after the hold time
                    if (hold_met) led_d = 2'b00;
                    else          hold_cnt_d = hold_cnt_q + HO_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Input registers and all FSM state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            r_q        <= 1'b0;
            r_prev_q   <= 1'b0;
            l_q        <= 1'b0;
            l_prev_q   <= 1'b0;
            round_q    <= '0;
            seq_q      <= '0;
            index_q    <= '0;
            led_q      <= 2'b00;
            correct_q  <= 1'b0;
            done_q     <= 1'b0;
            to_cnt_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= right_pressed;
            r_prev_q   <= r_q;
            l_q        <= left_pressed;
            l_prev_q   <= l_q;
            round_q    <= round_d;
            seq_q      <= seq_d;
            index_q    <= index_d;
            led_q      <= led_d;
            correct_q  <= correct_d;
            done_q     <= done_d;
            to_cnt_q   <= to_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_simon_input_checker.sv
// Bench for simon_input_checker: directed scenarios plus random attempts
// whose expected results come from a press-by-press model of the game rules.
module tb_simon_input_checker;

    localparam int SEQ_W = 8;
    localparam int IDX_W = 4;
    localparam int TO    = 100;
    localparam int H     = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [IDX_W-1:0] round;
    logic [SEQ_W-1:0] seq_bits;
    logic             right_pressed;
    logic             left_pressed;
    logic [1:0]       led_pressed;
    logic [IDX_W-1:0] index;
    logic             correct;
    logic             done;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    simon_input_checker #(
        .SEQ_W(SEQ_W), .IDX_W(IDX_W), .TIMEOUT_CYCLES(TO), .HOLD_CYCLES(H)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .round(round),
        .sequence_bits(seq_bits), .right_pressed(right_pressed),
        .left_pressed(left_pressed), .led_pressed(led_pressed),
        .index(index), .correct(correct), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // b[1] = left, b[0] = right, same encoding as led_pressed
    task automatic set_btn(input logic [1:0] b);
        left_pressed  = b[1];
        right_pressed = b[0];
    endtask

    // Pulse start, then scramble round/sequence to prove they were latched
    task automatic do_start(input logic [IDX_W-1:0] r, input logic [SEQ_W-1:0] s);
        round = r;
        seq_bits = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        round = IDX_W'($urandom);
        seq_bits = SEQ_W'($urandom);
        check("start_done", done, 0);
        check("start_index", index, 0);
    endtask

    // Called 2 cycles after the final correct press began; button held p cycles total.
    // done may rise only once the hold time has elapsed and the button is released.
    task automatic final_press(input int p);
        int t;
        int lim;
        repeat (p - 2) tick();
        set_btn(2'b00);
        t = p;
        lim = ((H > p) ? H : p) + 1;
        while (t < lim) begin
            tick();
            t++;
        end
        check("final_early", done, 0);
        tick();
        check("final_done", done, 1);
        check("final_correct", correct, 1);
        check("final_led", led_pressed, 0);
    endtask

    // One attempt; press number 'bad' is made with the wrong button (-1: none)
    task automatic run_attempt(input logic [SEQ_W-1:0] s, input logic [IDX_W-1:0] r,
                               input int bad, input bit rnd_timing);
        int last;
        int p;
        int g;
        logic [1:0] b;
        bit ok;
        last = (int'(r) >= SEQ_W) ? SEQ_W - 1 : int'(r);
        do_start(r, s);
        tick();
        for (int k = 0; k <= last; k++) begin
            ok = (k != bad);
            b = s[k] ? 2'b01 : 2'b10;
            if (!ok) b = ~b;
            p = rnd_timing ? int'($urandom_range(2, 12)) : 3;
            g = (((H + 3 - p) > 2) ? (H + 3 - p) : 2) + (rnd_timing ? int'($urandom_range(0, 4)) : 0);
            set_btn(b);
            tick();
            check("pre_done", done, 0);
            tick();
            check("press_led", led_pressed, b);
            check("press_index", index, ok ? k + 1 : k);
            if (!ok) begin
                check("wrong_done", done, 1);
                check("wrong_correct", correct, 0);
                set_btn(2'b00);
                tick();
                tick();
                return;
            end
            check("press_done", done, 0);
            if (k == last) begin
                final_press(p);
                return;
            end
            repeat (p - 2) tick();
            set_btn(2'b00);
            repeat (g) tick();
        end
    endtask

    initial begin
        logic [SEQ_W-1:0] rs;
        logic [IDX_W-1:0] rr;
        int lr;
        int bad;

        reset_n = 1'b0;
        start = 1'b0;
        round = '0;
        seq_bits = '0;
        set_btn(2'b00);
        #12;
        check("rst_led", led_pressed, 0);
        check("rst_index", index, 0);
        check("rst_correct", correct, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        tick();

        // Full correct round: L,R,R,L,L,R,R,L
        run_attempt(8'b01100110, 4'd7, -1, 1'b0);

        // Wrong third press
        run_attempt(8'b01100110, 4'd3, 2, 1'b0);

        // Timeout with no press
        do_start(4'd0, 8'h00);
        tick();
        repeat (TO - 1) tick();
        check("to_early", done, 0);
        tick();
        check("to_done", done, 1);
        check("to_correct", correct, 0);
        check("to_index", index, 0);

        // Both buttons rising together, then LED fades in DONE
        do_start(4'd2, 8'h05);
        tick();
        set_btn(2'b11);
        tick();
        tick();
        check("both_led", led_pressed, 2'b11);
        check("both_done", done, 1);
        check("both_correct", correct, 0);
        check("both_index", index, 0);
        repeat (H - 1) tick();
        check("both_led_held", led_pressed, 2'b11);
        tick();
        check("both_led_clear", led_pressed, 0);
        set_btn(2'b00);
        tick();
        tick();

        // Right held from before start must not count
        set_btn(2'b01);
        tick();
        tick();
        do_start(4'd0, 8'h01);
        repeat (6) tick();
        check("held_index", index, 0);
        check("held_done", done, 0);
        check("held_led", led_pressed, 0);
        set_btn(2'b00);
        tick();
        tick();
        set_btn(2'b01);
        tick();
        tick();
        check("held_press_led", led_pressed, 2'b01);
        check("held_press_index", index, 1);
        final_press(2);

        // Left pressed during HOLD with right still down is ignored
        do_start(4'd1, 8'b00000011);
        tick();
        set_btn(2'b01);
        tick();
        tick();
        check("ign_index0", index, 1);
        set_btn(2'b11);
        repeat (4) tick();
        check("ign_index", index, 1);
        check("ign_led", led_pressed, 2'b01);
        check("ign_done", done, 0);
        set_btn(2'b00);
        repeat (H + 3) tick();
        set_btn(2'b01);
        tick();
        tick();
        check("ign_press2_index", index, 2);
        final_press(2);

        // Async reset in HOLD with index 3, then a one-press round
        do_start(4'd7, 8'b01100110);
        tick();
        set_btn(2'b10);
        repeat (3) tick();
        set_btn(2'b00);
        repeat (H + 1) tick();
        set_btn(2'b01);
        repeat (3) tick();
        set_btn(2'b00);
        repeat (H + 1) tick();
        set_btn(2'b01);
        tick();
        tick();
        check("mid_index", index, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_led", led_pressed, 0);
        check("arst_index", index, 0);
        check("arst_correct", correct, 0);
        check("arst_done", done, 0);
        set_btn(2'b00);
        tick();
        reset_n = 1'b1;
        tick();
        run_attempt(8'h01, 4'd0, -1, 1'b0);

        // Random attempts, including rounds beyond the sequence length
        for (int n = 0; n < 16; n++) begin
            rs = SEQ_W'($urandom);
            rr = IDX_W'($urandom_range(0, 11));
            lr = (int'(rr) >= SEQ_W) ? SEQ_W - 1 : int'(rr);
            bad = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, lr));
            run_attempt(rs, rr, bad, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
